lsu_dm_master: RTL

Load/store initiator that drives the word-organised data memory port (clk, we, addr, wd, rd) on behalf of the rv32i core. It accepts one core request at a time over a valid/ready handshake and performs the memory access. Accepted request types are LB/LH/LW/LBU/LHU and SB/SH/SW. Sub-word stores are done as read-modify-write, because the memory only writes whole words. The block sits between the execute stage and DM.

---
 rtl/lsu_dm_master_if.sv | 30 +++
 rtl/lsu_dm_master.sv | 136 +++++++++++++
 2 files changed

// File: rtl/lsu_dm_master_if.sv
// Core request/response channel and word-organised data-memory port of the
// load/store initiator, bundled so that the LSU and its environment share one definition.
interface lsu_dm_master_if #(
  parameter int ADDR_W = 16,
  parameter int XLEN   = 32
) ();
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_funct3;
  logic [XLEN-1:0]   req_addr;
  logic [XLEN-1:0]   req_wdata;
  logic              resp_valid;
  logic [XLEN-1:0]   resp_rdata;
  logic              resp_err;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [XLEN-1:0]   dm_wd;
  logic [XLEN-1:0]   dm_rd;

  modport master (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, dm_rd,
    output req_ready, resp_valid, resp_rdata, resp_err, dm_we, dm_addr, dm_wd
  );

  modport slave (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, dm_rd,
    input  req_ready, resp_valid, resp_rdata, resp_err, dm_we, dm_addr, dm_wd
  );
endinterface

// File: rtl/lsu_dm_master.sv
// rv32i load/store initiator: one request at a time, with sub-word stores
// done as read-modify-write on the word-only data memory.
module lsu_dm_master #(
  parameter int ADDR_W = 16,
  parameter int XLEN   = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  lsu_dm_master_if.master  bus
);

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

  state_t      state;
  logic        store_q;
  logic [2:0]  f3_q;
  logic [1:0]  off_q;
  logic [15:0] wdata_q;

  function automatic logic req_is_err(input logic we, input logic [2:0] f3,
                                      input logic [XLEN-1:0] a);
    logic e;
    e = (a >> (ADDR_W + 2)) != '0;
    case (f3)
      3'b000:  e = e;
      3'b001:  e = e | a[0];
      3'b010:  e = e | (a[1:0] != 2'b00);
      3'b100:  e = e | we;
      3'b101:  e = e | we | a[0];
      default: e = 1'b1;
    endcase
    return e;
  endfunction

  function automatic logic [XLEN-1:0] lane_extract(input logic [XLEN-1:0] rd,
                                                   input logic [2:0] f3,
                                                   input logic [1:0] off);
    logic [7:0]      b;
    logic [15:0]     h;
    logic [XLEN-1:0] r;
    b = rd[{off, 3'b000} +: 8];
    h = rd[{off[1], 4'b0000} +: 16];
    case (f3)
      3'b000:  r = {{(XLEN-8){b[7]}}, b};
      3'b001:  r = {{(XLEN-16){h[15]}}, h};
      3'b100:  r = {{(XLEN-8){1'b0}}, b};
      3'b101:  r = {{(XLEN-16){1'b0}}, h};
      default: r = rd;
    endcase
    return r;
  endfunction

  function automatic logic [XLEN-1:0] lane_merge(input logic [XLEN-1:0] rd,
                                                 input logic [15:0] wd,
                                                 input logic [2:0] f3,
                                                 input logic [1:0] off);
    logic [XLEN-1:0] m;
    m = rd;
    if (f3 == 3'b000) m[{off, 3'b000} +: 8]    = wd[7:0];
    else              m[{off[1], 4'b0000} +: 16] = wd;
    return m;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      store_q         <= 1'b0;
      f3_q            <= 3'b000;
      off_q           <= 2'b00;
      wdata_q         <= '0;
      bus.req_ready   <= 1'b1;
      bus.resp_valid  <= 1'b0;
      bus.resp_err    <= 1'b0;
      bus.resp_rdata  <= '0;
      bus.dm_we       <= 1'b0;
      bus.dm_addr     <= '0;
      bus.dm_wd       <= '0;
    end else begin
      bus.dm_we      <= 1'b0;
      bus.resp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            store_q       <= bus.req_we;
            f3_q          <= bus.req_funct3;
            off_q         <= bus.req_addr[1:0];
            wdata_q       <= bus.req_wdata[15:0];
            bus.req_ready <= 1'b0;
            if (req_is_err(bus.req_we, bus.req_funct3, bus.req_addr)) begin
              // Rejected requests never touch DM; dm_addr keeps its old value.
              state          <= RESP;
              bus.resp_valid <= 1'b1;
              bus.resp_err   <= 1'b1;
              bus.resp_rdata <= '0;
            end else begin
              bus.dm_addr <= bus.req_addr[ADDR_W+1:2];
              if (bus.req_we && bus.req_funct3 == 3'b010) begin
                state      <= WR;
                bus.dm_we  <= 1'b1;
                bus.dm_wd  <= bus.req_wdata;
              end else begin
                state <= RD;
              end
            end
          end
        end
        RD: begin
          if (store_q) begin
            // dm_wd doubles as the merge register for the read-modify-write.
            state     <= WR;
            bus.dm_we <= 1'b1;
            bus.dm_wd <= lane_merge(bus.dm_rd, wdata_q, f3_q, off_q);
          end else begin
            state          <= RESP;
            bus.resp_valid <= 1'b1;
            bus.resp_err   <= 1'b0;
            bus.resp_rdata <= lane_extract(bus.dm_rd, f3_q, off_q);
          end
        end
        WR: begin
          state          <= RESP;
          bus.resp_valid <= 1'b1;
          bus.resp_err   <= 1'b0;
          bus.resp_rdata <= '0;
        end
        default: begin
          state          <= IDLE;
          bus.req_ready  <= 1'b1;
          bus.resp_err   <= 1'b0;
          bus.resp_rdata <= '0;
        end
      endcase
    end
  end

endmodule
